// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   Two-stage in-order front end: a decode stage (D) that splits the
//   instruction word into register fields, followed by an issue stage (I)
//   that presents the instruction downstream. A pending-write scoreboard
//   holds an instruction in D while any register it reads or writes is
//   still in flight. A saturating counter records the hazard-stall cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   instruction-input handshake
//   in_instr [31:0]       instruction word
//   flush                 synchronous kill of both stages
//   wb_valid / wb_addr    writeback completion, clears pending[wb_addr]
//   out_valid / out_ready issue handshake
//   out_instr, out_rs1, out_rs2, out_dest, out_we   issued instruction
//   pending [NUM_REGS]    scoreboard vector
//   stall_cnt [CNT_W]     saturating count of hazard-stall cycles
module decode_issue_stage #(
  parameter int REG_ADDR_W = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic                         flush,
  input  logic                         wb_valid,
  input  logic [REG_ADDR_W-1:0]        wb_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [REG_ADDR_W-1:0]        out_rs1,
  output logic [REG_ADDR_W-1:0]        out_rs2,
  output logic [REG_ADDR_W-1:0]        out_dest,
  output logic                         out_we,
  output logic [(2**REG_ADDR_W)-1:0]   pending,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int              NUM_REGS = 2**REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] dest;
    logic                  we;
  } uop_t;

  // Field placement depends on the group in the top three bits; every
  // 5-bit field is truncated to the register-address width.
  function automatic uop_t decode(input logic [31:0] instr);
    uop_t u;
    u.instr = instr;
    u.rs1   = instr[21 +: REG_ADDR_W];
    u.rs2   = instr[16 +: REG_ADDR_W];
    u.dest  = '0;
    u.we    = 1'b0;
    case (instr[31:29])
      3'b010: begin
        u.rs1  = instr[16 +: REG_ADDR_W];
        u.rs2  = instr[11 +: REG_ADDR_W];
        u.dest = instr[21 +: REG_ADDR_W];
        u.we   = 1'b1;
      end
      3'b110: begin
        u.rs1  = instr[16 +: REG_ADDR_W];
        u.rs2  = instr[16 +: REG_ADDR_W];
        u.dest = instr[21 +: REG_ADDR_W];
        u.we   = 1'b1;
      end
      default: ;
    endcase
    return u;
  endfunction

  logic                d_valid, i_valid;
  uop_t                d_uop, i_uop;
  logic [NUM_REGS-1:0] busy, pending_nxt;
  logic                hazard, d_adv, capture, issue;

  // busy marks every register D must not touch this cycle: pending writes
  // not being retired right now, plus the destination sitting in I.
  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    busy = pending;
    if (wb_valid) busy[wb_addr] = 1'b0;
    if (i_valid && i_uop.we) busy[i_uop.dest] = 1'b1;
    if (ZERO_REG) busy[0] = 1'b0;
  end

  assign hazard   = busy[d_uop.rs1] | busy[d_uop.rs2] | (d_uop.we & busy[d_uop.dest]);
  assign d_adv    = d_valid & ~hazard & (~i_valid | out_ready);
  assign in_ready = ~d_valid | d_adv;
  assign capture  = in_valid & in_ready & ~flush;
  assign issue    = i_valid & out_ready & ~flush;

  // The clear is applied before the set so an issue and a writeback to the
  // same register in one cycle leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_addr] = 1'b0;
    if (issue && i_uop.we) pending_nxt[i_uop.dest] = 1'b1;
    if (ZERO_REG) pending_nxt[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset along
  // with the valid bits; a stale pending bit after reset would deadlock D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      stall_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (!flush && d_valid && hazard && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      d_uop   <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (capture) begin
      d_valid <= 1'b1;
      d_uop   <= decode(in_instr);
    end else if (d_adv) begin
      d_valid <= 1'b0;
    end
  end

  // I drains on out_ready only when nothing replaces it from D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid <= 1'b0;
      i_uop   <= '0;
    end else if (flush) begin
      i_valid <= 1'b0;
    end else if (d_adv) begin
      i_valid <= 1'b1;
      i_uop   <= d_uop;
    end else if (out_ready) begin
      i_valid <= 1'b0;
    end
  end

  assign out_valid = i_valid;
  assign out_instr = i_uop.instr;
  assign out_rs1   = i_uop.rs1;
  assign out_rs2   = i_uop.rs2;
  assign out_dest  = i_uop.dest;
  assign out_we    = i_uop.we;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage
//   Drives the default instance (5-bit addresses, register 0 hardwired) with
//   a vector table, directed corner-case sequences and a random stream, all
//   checked every cycle against a behavioural model of the stage. A second
//   instance (3-bit addresses, no zero register, 2-bit stall counter)
//   covers field truncation and counter saturation.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, wb_valid, out_valid, out_ready, out_we;
  logic [31:0] in_instr, out_instr;
  logic [4:0]  wb_addr, out_rs1, out_rs2, out_dest;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  logic        p_in_valid, p_in_ready, p_flush, p_wb_valid, p_out_valid, p_out_ready, p_out_we;
  logic [31:0] p_in_instr, p_out_instr;
  logic [2:0]  p_wb_addr, p_out_rs1, p_out_rs2, p_out_dest;
  logic [7:0]  p_pending;
  logic [1:0]  p_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_dest(out_dest), .out_we(out_we),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  decode_issue_stage #(.REG_ADDR_W(3), .ZERO_REG(1'b0), .CNT_W(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_instr(p_in_instr), .flush(p_flush), .wb_valid(p_wb_valid), .wb_addr(p_wb_addr),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_instr(p_out_instr),
    .out_rs1(p_out_rs1), .out_rs2(p_out_rs2), .out_dest(p_out_dest), .out_we(p_out_we),
    .pending(p_pending), .stall_cnt(p_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] g, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c,
                                     input logic [10:0] tag);
    return {g, 3'b000, a, b, c, tag};
  endfunction

  // ---------------- behavioural model of the default instance ----------------
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] dest;
    logic       we;
  } dec_t;

  bit          m_dv, m_iv;
  logic [31:0] m_d, m_i;
  bit          m_pend [32];
  int          m_stall;

  function automatic dec_t dec(input logic [31:0] w);
    dec_t d;
    if (w[31:29] == 3'b010) begin
      d.rs1 = w[20:16]; d.rs2 = w[15:11]; d.dest = w[25:21]; d.we = 1'b1;
    end else if (w[31:29] == 3'b110) begin
      d.rs1 = w[20:16]; d.rs2 = w[20:16]; d.dest = w[25:21]; d.we = 1'b1;
    end else begin
      d.rs1 = w[25:21]; d.rs2 = w[20:16]; d.dest = 5'd0; d.we = 1'b0;
    end
    return d;
  endfunction

  // Register r blocks D: still awaiting its writeback (unless that writeback
  // is arriving now) or about to be written by the instruction in I.
  function automatic bit m_busy(input logic [4:0] r);
    dec_t di = dec(m_i);
    if (r == 5'd0) return 1'b0;
    if (m_pend[r] && !(wb_valid && wb_addr == r)) return 1'b1;
    if (m_iv && di.we && di.dest == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    dec_t dd = dec(m_d);
    if (!m_dv) return 1'b0;
    return m_busy(dd.rs1) || m_busy(dd.rs2) || (dd.we && m_busy(dd.dest));
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic bit m_ready();
    return !m_dv || (!m_hazard() && (!m_iv || out_ready));
  endfunction

  task automatic m_reset();
    m_dv = 0; m_iv = 0; m_d = '0; m_i = '0; m_stall = 0;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
  endtask

  task automatic model_check();
    check("in_ready", in_ready, m_ready());
    check("out_valid", out_valid, m_iv);
    if (m_iv) check("out_fields", {out_instr, out_rs1, out_rs2, out_dest, out_we}, {m_i, dec(m_i)});
    check("pending", pending, pend_vec());
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  // Drive one cycle's inputs just after the falling edge and compare.
  task automatic apply(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic wv, input logic [4:0] wa);
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    wb_valid = wv; wb_addr = wa;
    #1;
    model_check();
  endtask

  // Advance the model across the rising edge, then return to the falling edge.
  task automatic tick();
    bit   hz, adv, rdy, iss;
    dec_t di;
    @(posedge clk);
    hz  = m_hazard();
    adv = m_dv && !hz && (!m_iv || out_ready);
    rdy = !m_dv || adv;
    iss = m_iv && out_ready && !flush;
    di  = dec(m_i);
    if (wb_valid) m_pend[wb_addr] = 0;
    if (iss && di.we && di.dest != 5'd0) m_pend[di.dest] = 1;
    if (!flush && m_dv && hz && m_stall < 65535) m_stall++;
    if (flush) m_iv = 0;
    else if (adv) begin m_i = m_d; m_iv = 1; end
    else if (out_ready) m_iv = 0;
    if (flush) m_dv = 0;
    else if (in_valid && rdy) begin m_d = in_instr; m_dv = 1; end
    else if (adv) m_dv = 0;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    apply(1'b0, 32'h0, ordy, 1'b0, 1'b0, 5'd0);
  endtask

  // Asynchronous reset pulse from wherever the bench is; outputs must be at
  // reset values before any clock edge.
  task automatic do_reset();
    in_valid = 0; in_instr = '0; out_ready = 0; flush = 0; wb_valid = 0; wb_addr = '0;
    p_in_valid = 0; p_in_instr = '0; p_out_ready = 0; p_flush = 0; p_wb_valid = 0; p_wb_addr = '0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_fields", {out_instr, out_rs1, out_rs2, out_dest, out_we}, 64'h0);
    check("rst_pending", pending, 32'h0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic        iv;
    logic [31:0] ins;
    logic        ordy;
    logic        ov;
    logic [31:0] oi;
    logic        ird;
    logic [15:0] st;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    logic [31:0] ia, ib, ic, id, iw, iy, iz, iq;

    ia = mk(3'b000, 5'd1, 5'd2, 5'd0, 11'd1);
    ib = mk(3'b000, 5'd3, 5'd4, 5'd0, 11'd2);
    ic = mk(3'b000, 5'd5, 5'd6, 5'd0, 11'd3);
    id = mk(3'b000, 5'd7, 5'd8, 5'd0, 11'd4);
    // Four-deep stream: each word appears at out two cycles after its handshake.
    tbl[0] = '{1'b1, ia,    1'b1, 1'b0, 32'h0, 1'b1, 16'd0};
    tbl[1] = '{1'b1, ib,    1'b1, 1'b0, 32'h0, 1'b1, 16'd0};
    tbl[2] = '{1'b1, ic,    1'b1, 1'b1, ia,    1'b1, 16'd0};
    tbl[3] = '{1'b1, id,    1'b1, 1'b1, ib,    1'b1, 16'd0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, ic,    1'b1, 16'd0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, id,    1'b1, 16'd0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 16'd0};

    do_reset();

    // ---- 3-bit instance: field truncation and stall-counter saturation ----
    iw = mk(3'b010, 5'b11010, 5'd1, 5'd0, 11'h21);   // writes r2
    iy = mk(3'b000, 5'b11010, 5'd4, 5'd0, 11'h22);   // reads r2 through rs1
    p_out_ready = 1; p_in_valid = 1; p_in_instr = iw;
    wait_cycle();
    p_in_instr = iy; #1;
    check("p_in_ready", p_in_ready, 1'b1);
    wait_cycle();
    p_in_valid = 0; #1;
    check("p_out_valid_w", p_out_valid, 1'b1);
    check("p_out_dest", {p_out_dest, p_out_we}, {3'b010, 1'b1});
    wait_cycle();
    wait_cycle();
    #1;
    check("p_stall_2", p_stall_cnt, 2'd2);
    check("p_in_ready_stall", p_in_ready, 1'b0);
    wait_cycle();
    wait_cycle();
    p_wb_valid = 1; p_wb_addr = 3'd2; #1;
    check("p_stall_sat", p_stall_cnt, 2'd3);
    check("p_pending_set", p_pending, 8'h04);
    wait_cycle();
    p_wb_valid = 0; #1;
    check("p_out_valid_r", p_out_valid, 1'b1);
    check("p_out_instr_r", p_out_instr, iy);
    check("p_out_rs1_trunc", p_out_rs1, 3'b010);
    check("p_pending_clr", p_pending, 8'h00);
    check("p_stall_hold", p_stall_cnt, 2'd3);
    wait_cycle();

    // ---- vector table: back-to-back stream ----
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].iv, tbl[i].ins, tbl[i].ordy, 1'b0, 1'b0, 5'd0);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) check($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].oi);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ird);
      check($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].st);
      tick();
    end

    // ---- RAW hazard on r3 held until its writeback, which bypasses ----
    iw = mk(3'b010, 5'd3, 5'd1, 5'd2, 11'h31);
    iy = mk(3'b000, 5'd3, 5'd4, 5'd0, 11'h32);
    apply(1'b1, iw, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b1, iy, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    idle(1'b1);
    check("raw_issue_w", {out_valid, out_instr}, {1'b1, iw});
    tick();
    idle(1'b1);
    check("raw_held", {in_ready, out_valid}, 2'b00);
    check("raw_stall_1", stall_cnt, 16'd1);
    check("raw_pend3", pending[3], 1'b1);
    tick();
    idle(1'b1);
    check("raw_stall_2", stall_cnt, 16'd2);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    check("raw_bypass_ready", in_ready, 1'b1);
    check("raw_stall_3", stall_cnt, 16'd3);
    tick();
    idle(1'b1);
    check("raw_issue_r", {out_valid, out_instr, out_rs1}, {1'b1, iy, 5'd3});
    check("raw_pend_clr", pending, 32'h0);
    check("raw_stall_final", stall_cnt, 16'd3);
    tick();

    // ---- register 0 never pending, never a hazard ----
    iz = mk(3'b110, 5'd0, 5'd5, 5'd0, 11'h41);
    iq = mk(3'b000, 5'd0, 5'd0, 5'd0, 11'h42);
    apply(1'b1, iz, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b1, iq, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    idle(1'b1);
    check("r0_issue_z", {out_valid, out_instr}, {1'b1, iz});
    check("r0_no_hazard", in_ready, 1'b1);
    tick();
    idle(1'b1);
    check("r0_issue_q", {out_valid, out_instr}, {1'b1, iq});
    check("r0_pending", pending, 32'h0);
    check("r0_stall", stall_cnt, 16'd3);
    tick();

    // ---- back-pressure: three cycles of out_ready=0 with a word waiting ----
    apply(1'b1, ia, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b1, ib, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, ic, 1'b0, 1'b0, 1'b0, 5'd0);
      check($sformatf("bp%0d_hold", k), {in_ready, out_valid, out_instr}, {2'b01, ia});
      tick();
    end
    apply(1'b1, ic, 1'b1, 1'b0, 1'b0, 5'd0);
    check("bp_resume_a", {in_ready, out_instr}, {1'b1, ia});
    tick();
    idle(1'b1);
    check("bp_resume_b", {out_valid, out_instr}, {1'b1, ib});
    tick();
    idle(1'b1);
    check("bp_resume_c", {out_valid, out_instr}, {1'b1, ic});
    tick();
    idle(1'b1);
    check("bp_drained", out_valid, 1'b0);
    tick();

    // ---- flush with both stages full; scoreboard survives ----
    iw = mk(3'b010, 5'd7, 5'd1, 5'd2, 11'h51);
    apply(1'b1, iw, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b1, ia, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b1, ib, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    check("fl_before", {out_valid, in_ready, out_instr}, {2'b10, ia});
    tick();
    idle(1'b1);
    check("fl_after", {out_valid, in_ready}, 2'b01);
    check("fl_pending", pending, 32'h0000_0080);
    tick();

    // ---- asynchronous reset in the middle of a stall on r7 ----
    iq = mk(3'b000, 5'd7, 5'd0, 5'd0, 11'h61);
    apply(1'b1, iq, 1'b1, 1'b0, 1'b0, 5'd0); tick();
    idle(1'b1); tick();
    idle(1'b1);
    check("mid_stall", {in_ready, stall_cnt}, {1'b0, 16'd4});
    do_reset();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = mk(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 11'($urandom));
      apply(1'($urandom_range(0, 1)), ins, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
